// File: rtl/spi_seq_arbiter.sv
// ============================================================================
// Module   : spi_seq_arbiter
// Brief    : Round-robin sequencer that shares one spi_master between two
//            requesters by programming its register file over the CPU bus.
//            Optional WAIT_IRQ timeout enabled by defining SPI_SEQ_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_seq_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h20,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic        clk_cpu,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_div,
  input  logic [31:0] req0_wdata,
  input  logic [7:0]  req0_ctrl,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  output logic        req0_err,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_div,
  input  logic [31:0] req1_wdata,
  input  logic [7:0]  req1_ctrl,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic        req1_err,

  output logic [31:0] spi_addr,
  output logic [31:0] spi_wdata,
  output logic [3:0]  spi_wstrb,
  output logic        spi_valid,
  output logic        spi_instr,
  input  logic        spi_ready,
  input  logic [31:0] spi_rdata,
  input  logic        spi_irq
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_DIV   = 3'd1,
    S_WR_DATA  = 3'd2,
    S_WR_CFG   = 3'd3,
    S_WR_GO    = 3'd4,
    S_WAIT_IRQ = 3'd5,
    S_RD_DATA  = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t      state, state_n, after;
  logic        gap, gap_n;
  logic        owner;
  logic        last_grant;
  logic [7:0]  div_q, ctrl_q, last_div;
  logic [31:0] wdata_q;
  logic        div_known;
  logic        pick0, pick1, grant0, grant1;
  logic [7:0]  sel_div;
  logic        access, is_write, hs;
  logic [1:0]  addr_off;
  logic [31:0] bus_data;
  logic        timeout_hit;

  // last_grant = 1 means req1 was granted last, so req0 wins a tie
  assign pick0   = req0_valid && (!req1_valid || last_grant);
  assign pick1   = req1_valid && !pick0;
  assign sel_div = pick1 ? req1_div : req0_div;

  always_comb begin
    state_n  = state;
    gap_n    = gap;
    after    = S_IDLE;
    grant0   = 1'b0;
    grant1   = 1'b0;
    access   = 1'b0;
    is_write = 1'b1;
    addr_off = 2'd0;
    bus_data = 32'h0;
    case (state)
      S_IDLE: begin
        gap_n = 1'b0;
        if (pick0 || pick1) begin
          grant0  = pick0;
          grant1  = pick1;
          state_n = (div_known && sel_div == last_div) ? S_WR_DATA : S_WR_DIV;
        end
      end
      S_WR_DIV: begin
        access   = 1'b1;
        addr_off = 2'd0;
        bus_data = {24'h0, div_q};
        after    = S_WR_DATA;
      end
      S_WR_DATA: begin
        access   = 1'b1;
        addr_off = 2'd1;
        bus_data = wdata_q;
        after    = S_WR_CFG;
      end
      S_WR_CFG: begin
        access   = 1'b1;
        addr_off = 2'd3;
        bus_data = {23'h0, 1'b0, ctrl_q};
        after    = S_WR_GO;
      end
      S_WR_GO: begin
        access   = 1'b1;
        addr_off = 2'd3;
        bus_data = {23'h0, 1'b1, ctrl_q};
        after    = S_WAIT_IRQ;
      end
      S_WAIT_IRQ: begin
        if (spi_irq)          state_n = S_RD_DATA;
        else if (timeout_hit) state_n = S_DONE;
      end
      S_RD_DATA: begin
        access   = 1'b1;
        is_write = 1'b0;
        addr_off = 2'd2;
        after    = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Each access state spends one cycle with valid low after its handshake
    if (access) begin
      if (gap) begin
        state_n = after;
        gap_n   = 1'b0;
      end else if (spi_ready) begin
        gap_n = 1'b1;
      end
    end

    spi_valid = access && !gap;
    hs        = spi_valid && spi_ready;
    spi_addr  = access ? (BASE_ADDR + {30'h0, addr_off}) : 32'h0;
    spi_wdata = (access && is_write) ? bus_data : 32'h0;
    spi_wstrb = (access && is_write) ? 4'b1111 : 4'b0000;
    spi_instr = 1'b0;
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      state      <= S_IDLE;
      gap        <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      div_q      <= 8'h0;
      ctrl_q     <= 8'h0;
      wdata_q    <= 32'h0;
      last_div   <= 8'h0;
      div_known  <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_rdata <= 32'h0;
      req1_rdata <= 32'h0;
    end else begin
      state      <= state_n;
      gap        <= gap_n;
      req0_ready <= grant0;
      req1_ready <= grant1;
      if (grant0 || grant1) begin
        owner      <= grant1;
        last_grant <= grant1;
        div_q      <= sel_div;
        wdata_q    <= grant1 ? req1_wdata : req0_wdata;
        ctrl_q     <= grant1 ? req1_ctrl  : req0_ctrl;
      end
      if (state == S_WR_DIV && hs) begin
        last_div  <= div_q;
        div_known <= 1'b1;
      end
      if (state == S_RD_DATA && hs) begin
        if (owner) req1_rdata <= spi_rdata;
        else       req0_rdata <= spi_rdata;
      end
      // A timed-out transfer leaves the divisor state of spi_master unknown
      if (timeout_hit) div_known <= 1'b0;
    end
  end

  assign req0_done = (state == S_DONE) && !owner;
  assign req1_done = (state == S_DONE) && owner;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wait_cnt;
  logic        timed_out;

  assign timeout_hit = (state == S_WAIT_IRQ) && !spi_irq && (wait_cnt == TO_LAST);

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      wait_cnt  <= 16'h0;
      timed_out <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT_IRQ) ? wait_cnt + 16'd1 : 16'h0;
      if (grant0 || grant1) timed_out <= 1'b0;
      if (timeout_hit)      timed_out <= 1'b1;
    end
  end

  assign req0_err = req0_done && timed_out;
  assign req1_err = req1_done && timed_out;
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
  assign req0_err       = 1'b0;
  assign req1_err       = 1'b0;
`endif

endmodule

`default_nettype wire
